alu4_seq_ctrl: RTL and testbench
================================

Name: alu4_seq_ctrl

Overview:
Multi-cycle sequencer that drives the 4-bit combinational ALU slice (alu4_core) to execute 8-bit ADD/SUB/AND/OR/XOR and a 4x4 unsigned multiply.
- Operates nibble-serially; 8-bit ops chain carry between nibbles.
- Sits between the tt_um_Ariggan_Knight_ALU4 pin decode and the ALU slice.
- Owns operand/result registers, the start/busy/done handshake and status flags.

Parameters:
W_DATA, 8, operand/result width (fixed: two nibbles).
W_NIB, 4, ALU slice width.
MUL_STEPS, 4, shift-add iterations for MUL (equals W_NIB).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
ena  in  1  design enable; 0 freezes all state (stall).
start  in  1  request; sampled only in IDLE.
op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110/111 reserved.
a  in  8  operand A; MUL uses a[3:0].
b  in  8  operand B; MUL uses b[3:0].
alu_a  out  4  slice operand A.
alu_b  out  4  slice operand B.
alu_fn  out  2  slice function: 00 ADD (a+b+cin), 01 AND, 10 OR, 11 XOR.
alu_cin  out  1  slice carry-in.
alu_y  in  4  slice result (combinational, same cycle).
alu_cout  in  1  slice carry-out.
result  out  8  final result; held until next accepted start.
carry  out  1  ADD: carry-out; SUB: 1 = no borrow; others 0.
zero  out  1  result == 0.
err  out  1  reserved op executed.
busy  out  1  high in LO, HI, MUL.
done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (asynchronous): state=IDLE; result, carry, zero, err, done, busy = 0; alu_* = 0.
- ena=0: no state, register or step-counter change; outputs hold.
- IDLE, start=1:
  - Latch op, a, b; clear err.
  - Valid non-MUL op -> LO.
  - MUL -> MUL with acc_hi=0, acc_lo=b[3:0], step=0.
  - Reserved op -> DONE with result=0, err=1, carry=0.
- start is ignored in every state except IDLE; no queuing.
- LO:
  - Drive a[3:0] and b'[3:0], where b'=~b for SUB, else b.
  - alu_cin = 1 for SUB, else 0.
  - Capture alu_y into res[3:0] and alu_cout into c_reg; -> HI.
- HI:
  - Drive a[7:4] and b'[7:4]; alu_cin = c_reg for ADD/SUB, 0 for logic ops.
  - Capture res[7:4]; carry = alu_cout for ADD/SUB, else 0; -> DONE.
- MUL step:
  - Drive alu_a=acc_hi, alu_b = acc_lo[0] ? a[3:0] : 0, fn ADD, cin 0.
  - Next state of {cout, y, acc_lo} is that 9-bit value shifted right by 1: acc_hi={cout, y[3:1]}, acc_lo={y[0], acc_lo[3:1]}.
  - step increments; after step 3 -> DONE with result={acc_hi, acc_lo}, carry=0.
- DONE:
  - done=1, busy=0; zero computed from final result.
  - result, carry, zero, err update on the edge into DONE and are valid while done=1.
  - -> IDLE unconditionally.
- Latency from the accepted-start edge (edge 1) to done visible:
  - ADD/SUB/logic: after edge 3.
  - MUL: after edge 5.
  - Reserved op: after edge 1.
- Reset mid-operation aborts to IDLE and clears all outputs; there is no partial result.
- alu_* drive 0 in IDLE and DONE.

Decomposition:
- Package alu4_pkg holds:
  - op_t enum (3 bits) and alu_fn_t enum (2 bits).
  - state_t: IDLE, LO, HI, MUL, DONE.
  - Constants W_NIB=4 and MUL_STEPS=4.
- Single module; the shift-add datapath stays inline.
- alu4_core is instantiated by the parent, not inside this block.

Test Plan:
- ADD a=0x3C, b=0x4F -> result 0x8B, carry 0, zero 0; done after edge 3; busy high exactly 2 cycles.
- SUB 0x50-0x51 -> 0xFF, carry 0. SUB 0x51-0x50 -> 0x01, carry 1. SUB 0x80-0x80 -> 0x00, carry 1, zero 1.
- Logic: XOR 0xA5^0xFF -> 0x5A; AND 0xF0&0x0F -> 0x00, zero 1; OR 0x0A|0x50 -> 0x5A. carry 0 for all.
- MUL a=0xF, b=0xF -> 0xE1 after edge 5. MUL 0x0*0x9 -> 0x00, zero 1. A start pulse during busy is ignored and the result is unchanged.
- Stall and reset:
  - ena=0 for 3 cycles during HI -> done is delayed by exactly 3 cycles, result unchanged (0x8B case).
  - rst_n low during MUL step 2 -> all outputs 0 immediately, state IDLE.
- Reserved op 110 -> err 1, result 0x00, done after edge 1. A following ADD clears err.

Source files
------------

// File: rtl/alu4_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu4_pkg;

  localparam int W_DATA    = 8;
  localparam int W_NIB     = 4;
  localparam int MUL_STEPS = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101
  } op_t;

  typedef enum logic [1:0] {
    FN_ADD = 2'b00,
    FN_AND = 2'b01,
    FN_OR  = 2'b10,
    FN_XOR = 2'b11
  } alu_fn_t;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    MUL,
    DONE
  } state_t;

  function automatic logic is_reserved(input logic [2:0] opcode);
    return opcode > 3'(OP_MUL);
  endfunction

endpackage

// File: rtl/alu4_seq_ctrl.sv
// Sequencer driving a 4-bit ALU slice: two-nibble 8-bit ops with carry chaining
// and a 4-step shift-add 4x4 multiply, with start/busy/done handshake.
module alu4_seq_ctrl
  import alu4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [W_DATA-1:0] a,
  input  logic [W_DATA-1:0] b,
  output logic [W_NIB-1:0]  alu_a,
  output logic [W_NIB-1:0]  alu_b,
  output logic [1:0]        alu_fn,
  output logic              alu_cin,
  input  logic [W_NIB-1:0]  alu_y,
  input  logic              alu_cout,
  output logic [W_DATA-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              err,
  output logic              busy,
  output logic              done
);

  localparam int                W_STEP    = $clog2(MUL_STEPS);
  localparam logic [W_STEP-1:0] LAST_STEP = W_STEP'(MUL_STEPS - 1);

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [W_DATA-1:0]   a_q, a_d, b_q, b_d;
  logic [W_NIB-1:0]    res_lo_q, res_lo_d;
  logic                c_q, c_d;
  logic [W_NIB-1:0]    acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [W_STEP-1:0]   step_q, step_d;
  logic [W_DATA-1:0]   result_q, result_d;
  logic                carry_q, carry_d, zero_q, zero_d, err_q, err_d;

  logic                is_sub, is_arith;
  logic [W_DATA-1:0]   b_eff;
  alu_fn_t             op_fn, fn;

  assign is_sub   = (op_q == 3'(OP_SUB));
  assign is_arith = (op_q == 3'(OP_ADD)) || is_sub;
  assign b_eff    = is_sub ? ~b_q : b_q;

  // NOTE: ena gates every register at the flop, so a stall freezes state, datapath
  // and step counter together; sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else if (ena) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) begin
        if (is_reserved(op))          state_d = DONE;
        else if (op == 3'(OP_MUL))    state_d = MUL;
        else                          state_d = LO;
      end
      LO:      state_d = HI;
      HI:      state_d = DONE;
      MUL:     if (step_q == LAST_STEP) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every variable gets a default before the case so no latch can be inferred.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_lo_d = res_lo_q;
    c_d      = c_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    step_d   = step_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: if (start) begin
        op_d     = op;
        a_d      = a;
        b_d      = b;
        err_d    = 1'b0;
        acc_hi_d = '0;
        acc_lo_d = b[W_NIB-1:0];
        step_d   = '0;
        if (is_reserved(op)) begin
          result_d = '0;
          carry_d  = 1'b0;
          zero_d   = 1'b1;
          err_d    = 1'b1;
        end
      end
      LO: begin
        res_lo_d = alu_y;
        c_d      = alu_cout;
      end
      HI: begin
        result_d = {alu_y, res_lo_q};
        carry_d  = is_arith & alu_cout;
        zero_d   = ({alu_y, res_lo_q} == '0);
      end
      MUL: begin
        // {cout, y, acc_lo} shifted right by one
        acc_hi_d = {alu_cout, alu_y[W_NIB-1:1]};
        acc_lo_d = {alu_y[0], acc_lo_q[W_NIB-1:1]};
        step_d   = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          result_d = {acc_hi_d, acc_lo_d};
          carry_d  = 1'b0;
          zero_d   = ({acc_hi_d, acc_lo_d} == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_lo_q <= '0;
      c_q      <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      step_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (ena) begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_lo_q <= res_lo_d;
      c_q      <= c_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      step_q   <= step_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    unique case (op_q)
      3'(OP_AND): op_fn = FN_AND;
      3'(OP_OR):  op_fn = FN_OR;
      3'(OP_XOR): op_fn = FN_XOR;
      default:    op_fn = FN_ADD;
    endcase
  end

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    fn      = FN_ADD;
    alu_cin = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      LO: begin
        alu_a   = a_q[W_NIB-1:0];
        alu_b   = b_eff[W_NIB-1:0];
        fn      = op_fn;
        alu_cin = is_sub;
        busy    = 1'b1;
      end
      HI: begin
        alu_a   = a_q[W_DATA-1:W_NIB];
        alu_b   = b_eff[W_DATA-1:W_NIB];
        fn      = op_fn;
        alu_cin = is_arith & c_q;
        busy    = 1'b1;
      end
      MUL: begin
        alu_a = acc_hi_q;
        alu_b = acc_lo_q[0] ? a_q[W_NIB-1:0] : '0;
        busy  = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign alu_fn = fn;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu4_seq_ctrl.sv
// Self-checking bench: models the 4-bit slice, checks results against arithmetic.
module tb_alu4_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [7:0] a = '0, b = '0;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [1:0] alu_fn;
  logic       alu_cin, alu_cout;
  logic [7:0] result;
  logic       carry, zero, err, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  alu4_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .op(op), .a(a), .b(b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fn(alu_fn), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .result(result), .carry(carry),
    .zero(zero), .err(err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the alu4_core slice.
  always_comb begin
    alu_y    = '0;
    alu_cout = 1'b0;
    case (alu_fn)
      2'b00: {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
      2'b01: alu_y = alu_a & alu_b;
      2'b10: alu_y = alu_a | alu_b;
      default: alu_y = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                                 output logic [7:0] r, output logic c, output logic e,
                                 output int lat, output int busy_cyc);
    int s;
    r = 8'h00; c = 1'b0; e = 1'b0; lat = 3; busy_cyc = 2;
    case (o)
      3'd0: begin s = int'(av) + int'(bv); r = 8'(s); c = (s > 255); end
      3'd1: begin r = 8'(av - bv); c = (av >= bv); end
      3'd2: r = av & bv;
      3'd3: r = av | bv;
      3'd4: r = av ^ bv;
      3'd5: begin r = {4'h0, av[3:0]} * {4'h0, bv[3:0]}; lat = 5; busy_cyc = 4; end
      default: begin e = 1'b1; lat = 1; busy_cyc = 0; end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op; optionally stall after edge stall_at for stall_len edges,
  // optionally poke start with junk operands while busy.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input int stall_at, input int stall_len,
                        input bit poke);
    logic [7:0] er;
    logic ec, ee;
    int elat, ebusy, cycles, busy_seen;
    ref_op(o, av, bv, er, ec, ee, elat, ebusy);
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    cycles = 1;
    busy_seen = 0;
    while (!done && cycles < 40) begin
      if (busy) busy_seen++;
      ena = !(cycles >= stall_at && cycles < stall_at + stall_len);
      if (poke && cycles == 2) begin
        start = 1'b1; op = 3'd0; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    ena = 1'b1;
    start = 1'b0;
    check({tag, " latency"}, cycles, elat + stall_len);
    check({tag, " busy_cycles"}, busy_seen, ebusy + stall_len);
    check({tag, " done"}, done, 1);
    check({tag, " busy_in_done"}, busy, 0);
    check({tag, " result"}, result, er);
    check({tag, " carry"}, carry, ec);
    check({tag, " zero"}, zero, (er == 8'h00));
    check({tag, " err"}, err, ee);
    check({tag, " alu_in_done"}, {alu_a, alu_b, alu_fn, alu_cin}, 0);
    tick();
    check({tag, " done_pulse"}, done, 0);
    check({tag, " result_held"}, result, er);
  endtask

  initial begin
    logic [2:0] ro;
    logic [7:0] ra, rb;

    tick();
    check("reset outputs", {result, carry, zero, err, busy, done}, 0);
    check("reset alu", {alu_a, alu_b, alu_fn, alu_cin}, 0);
    rst_n = 1'b1;
    tick();
    check("idle after reset", {busy, done}, 0);

    run_op("add_3c_4f", 3'd0, 8'h3C, 8'h4F, 100, 0, 1'b0);
    run_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 100, 0, 1'b0);
    run_op("sub_50_51", 3'd1, 8'h50, 8'h51, 100, 0, 1'b0);
    run_op("sub_51_50", 3'd1, 8'h51, 8'h50, 100, 0, 1'b0);
    run_op("sub_80_80", 3'd1, 8'h80, 8'h80, 100, 0, 1'b0);
    run_op("xor_a5_ff", 3'd4, 8'hA5, 8'hFF, 100, 0, 1'b0);
    run_op("and_f0_0f", 3'd2, 8'hF0, 8'h0F, 100, 0, 1'b0);
    run_op("or_0a_50",  3'd3, 8'h0A, 8'h50, 100, 0, 1'b0);
    run_op("mul_f_f",   3'd5, 8'hAF, 8'h3F, 100, 0, 1'b0);
    run_op("mul_0_9",   3'd5, 8'h50, 8'hC9, 100, 0, 1'b0);
    run_op("mul_poke",  3'd5, 8'h07, 8'h0B, 100, 0, 1'b1);
    run_op("add_poke",  3'd0, 8'h12, 8'h34, 100, 0, 1'b1);
    run_op("add_stall", 3'd0, 8'h3C, 8'h4F, 2, 3, 1'b0);
    run_op("rsv_110",   3'd6, 8'h12, 8'h34, 100, 0, 1'b0);
    run_op("add_clr",   3'd0, 8'h01, 8'h02, 100, 0, 1'b0);
    run_op("rsv_111",   3'd7, 8'hFF, 8'hFF, 100, 0, 1'b0);

    // Leave nonzero result/carry, then reset in the middle of a MUL.
    run_op("sub_pre_rst", 3'd1, 8'h51, 8'h50, 100, 0, 1'b0);
    op = 3'd5; a = 8'h0F; b = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mul busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("reset mid-mul outputs", {result, carry, zero, err, busy, done}, 0);
    check("reset mid-mul alu", {alu_a, alu_b, alu_fn, alu_cin}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle after mid reset", {busy, done}, 0);
    run_op("add_after_rst", 3'd0, 8'h3C, 8'h4F, 100, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 100, 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
